// File: rtl/mood_channel_bank_if.sv
// Bus bundle for mood_channel_bank: tick/update requests in, counter values,
// readback and level/decay events out.
interface mood_channel_bank_if #(
  parameter int NCH = 3,
  parameter int W   = 7
);
  logic             tick;
  logic [NCH-1:0]   inc;
  logic [NCH-1:0]   dec;
  logic             load;
  logic [2:0]       sel;
  logic [NCH*W-1:0] values;
  logic [W-1:0]     value;
  logic [2*NCH-1:0] level;
  logic [NCH-1:0]   changed;
  logic             decay_pulse;

  modport master (
    output tick, inc, dec, load, sel,
    input  values, value, level, changed, decay_pulse
  );

  modport slave (
    input  tick, inc, dec, load, sel,
    output values, value, level, changed, decay_pulse
  );
endinterface

// File: rtl/mood_channel_bank.sv
// Bank of NCH saturating mood counters with periodic decay toward REST and a
// registered quartile level per channel. Define MOOD_HYSTERESIS_EN to add level hysteresis.
module mood_channel_bank #(
  parameter int NCH       = 3,
  parameter int W         = 7,
  parameter int REST      = 64,
  parameter int DECAY_DIV = 16,
  parameter int HYST      = 4
) (
  input logic                clk,
  input logic                rst_n,
  mood_channel_bank_if.slave bus
);

  localparam int Q = 1 << (W - 2);
`ifdef MOOD_HYSTERESIS_EN
  localparam int HYST_EFF = HYST;
`else
  // With a zero margin the hysteresis rule reduces exactly to level = q(value).
  localparam int HYST_EFF = 0 * HYST;
`endif

  localparam logic [W-1:0] REST_V  = W'(REST);
  localparam logic [W-1:0] MAX_V   = '1;
  localparam logic [W-1:0] ONE_V   = W'(1);
  localparam logic [1:0]   LVL_RST = REST_V[W-1:W-2];
  localparam logic [7:0]   DLAST   = 8'(DECAY_DIV - 1);
  localparam logic [W:0]   Q_EXT   = (W+1)'(Q);
  localparam logic [W:0]   H_EXT   = (W+1)'(HYST_EFF);

  logic [NCH*W-1:0] vals;
  logic [2*NCH-1:0] lvls;
  logic [NCH-1:0]   chg;
  logic [7:0]       dcnt;
  logic             decay_due;
  logic             decay_step;
  logic             pulse;

  assign decay_due  = bus.tick & (dcnt == DLAST);
  assign decay_step = decay_due & ~bus.load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt  <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= decay_step;
      if (bus.tick) begin
        if (bus.load || dcnt == DLAST)
          dcnt <= '0;
        else
          dcnt <= dcnt + 8'd1;
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [W-1:0] v;
    logic [W-1:0] v_n;
    logic [1:0]   l;
    logic [1:0]   l_n;
    logic         ch;
    logic [1:0]   q;
    logic [W:0]   v_ext;
    logic [W:0]   lo;
    logic [W:0]   hi;

    assign q     = v[W-1:W-2];
    assign v_ext = {1'b0, v};
    assign lo    = {1'b0, q, {(W-2){1'b0}}};
    assign hi    = lo + Q_EXT;

    always_comb begin
      v_n = v;
      if (bus.tick) begin
        if (bus.load)
          v_n = REST_V;
        else if (bus.inc[c] && !bus.dec[c]) begin
          if (v != MAX_V) v_n = v + ONE_V;
        end else if (bus.dec[c] && !bus.inc[c]) begin
          if (v != '0) v_n = v - ONE_V;
        end else if (!bus.inc[c] && !bus.dec[c] && decay_due) begin
          if (v > REST_V)
            v_n = v - ONE_V;
          else if (v < REST_V)
            v_n = v + ONE_V;
        end
      end
    end

    // Level only moves once the value is HYST counts inside the new quartile.
    always_comb begin
      l_n = l;
      if (q > l && v_ext >= lo + H_EXT)
        l_n = q;
      else if (q < l && v_ext + H_EXT < hi)
        l_n = q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v  <= REST_V;
        l  <= LVL_RST;
        ch <= 1'b0;
      end else begin
        v  <= v_n;
        l  <= l_n;
        ch <= (l_n != l);
      end
    end

    assign vals[c*W +: W] = v;
    assign lvls[2*c +: 2] = l;
    assign chg[c]         = ch;
  end

  always_comb begin
    bus.value = '0;
    for (int unsigned c = 0; c < NCH; c++)
      if (bus.sel == 3'(c)) bus.value = vals[c*W +: W];
  end

  assign bus.values      = vals;
  assign bus.level       = lvls;
  assign bus.changed     = chg;
  assign bus.decay_pulse = pulse;

endmodule

// File: doc/mood_channel_bank.md
# mood_channel_bank

Parametrised bank of NCH saturating mood counters (energy, stress, pleasure, …), each with a registered 2-bit level indicator and automatic decay toward a rest value. It is the next-generation replacement for the individual fixed-width counter-plus-classifier pairs: channel count, width, rest point and decay rate are parameters. Decay and level-change events are added, and indicator hysteresis is optional. It sits between the stimulus/sleep controllers (which drive inc/dec) and the output mux.

## Interface
- NCH, 3, number of channels (1..8)
- W, 7, counter width in bits (≥3)
- REST, 64, reset/load/decay target value (0..2^W-1)
- DECAY_DIV, 16, ticks per decay step (≥1, ≤256)
- HYST, 4, hysteresis margin in counts (0 ≤ HYST < 2^(W-3))

- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- tick  in  1  game-time step enable; all counter updates happen only on cycles with tick=1
- inc  in  NCH  per-channel increment request, sampled when tick=1
- dec  in  NCH  per-channel decrement request, sampled when tick=1
- load  in  1  sampled when tick=1; sets all channels to REST and clears the decay divider
- sel  in  3  channel select for readback (values ≥NCH read as 0)
- values  out  NCH*W  all counter values, channel c at [c*W +: W]
- value  out  W  combinational mux of values by sel
- level  out  2*NCH  registered indicator per channel, channel c at [2c +: 2]
- changed  out  NCH  one-cycle pulse when the level of channel c changes
- decay_pulse  out  1  one-cycle pulse after each decay step

## Operation
- Q = 2^(W-2). Raw quartile q(v) = v[W-1:W-2]: 0 for v<Q, 1 for v<2Q, 2 for v<3Q, 3 otherwise.
- Decay divider dcnt counts 0..DECAY_DIV-1 on each tick and wraps. decay_due = tick & (dcnt==DECAY_DIV-1).
- Per channel, on a tick, in priority order:
  - load: value←REST.
  - inc&~dec: value←min(value+1, 2^W-1).
  - dec&~inc: value←max(value-1, 0).
  - inc&dec: hold.
  - neither, and decay_due: step one toward REST (hold if equal).
- A channel with inc or dec asserted skips decay on that tick. Other channels still decay.
- No tick: all values, dcnt and levels driven by value hold; load/inc/dec are ignored.
- load clears dcnt to 0 and suppresses decay on that tick.
- Level register: without hysteresis, level←q(value) every cycle.
- changed[c] is registered and asserted in the same cycle the new level first appears.
- decay_pulse is registered and asserted the cycle after the decay_due tick, for 1 cycle.

## Timing
- Reset (async assert, sync release on clk rising edge): values=REST, dcnt=0, level=q(REST) per channel (2 for defaults), changed=0, decay_pulse=0.
- Tick at edge N → values updated at N+1; level/changed at N+2.
- decay_pulse is coincident with the decayed value (N+1).
- value follows sel combinationally, with no added latency.
- Reset asserted mid-operation forces reset values immediately; no pending pulse survives.
- Saturation: repeated inc at 2^W-1 or dec at 0 holds the value. The level does not change and changed stays 0.

## Configuration
- MOOD_HYSTERESIS_EN defined: level moves up to q only if q>level and value ≥ q*Q+HYST. It moves down to q only if q<level and value+HYST < (q+1)*Q; otherwise it holds. Multi-quartile jumps (via load) obey the same rule.
- Not defined: HYST is ignored; level = q(value) registered, with no hysteresis.

## Test plan
- Reset with defaults → values all 64, level all 2, changed 0. Then release and hold tick=0 for 20 cycles → nothing changes.
- Channel 0: inc on 70 consecutive ticks → value saturates at 127. Level becomes 3 two cycles after the tick that reaches 96 (macro off) or 100 (macro on). changed[0] pulses exactly once.
- Channel 1: inc&dec together for 10 ticks → value stays 64, no changed pulse. Channel 2 dec in the same ticks → 54.
- Channel 0 at 70, no inputs, 16 ticks → value 69 after the 16th tick, with decay_pulse one cycle. 15 further ticks → still 69.
- MOOD_HYSTERESIS_EN, HYST=4: dec from 64 → level 2 held at 63..60 and becomes 1 at 59. Then inc → level 1 held up to 67 and becomes 2 at 68. Macro off: level changes at 63 and at 64.
- Mid-run load with tick at dcnt=9 → all values 64 next cycle, dcnt=0, and the next decay occurs exactly 16 ticks later. Async rst_n pulse between clock edges → outputs return to reset values before the next edge.
